// File: rtl/mem_access_pkg.sv
// ============================================================================
// mem_access_pkg : shared constants, state enum and offset helper for the
//                  load/store access unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_access_pkg;

    localparam int DWORD_BYTES = 8;

    // Access size code, taken from funct3[1:0]
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam logic [2:0] F3_LOAD_RSVD = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LD_REQ   = 3'd1,
        S_LD_CAP   = 3'd2,
        S_ST_RD    = 3'd3,
        S_ST_MERGE = 3'd4,
        S_ST_WRITE = 3'd5,
        S_DONE     = 3'd6
    } state_e;

    // Clears the offset bits below the access size
    function automatic logic [2:0] align_off(input logic [1:0] sz, input logic [2:0] off);
        case (sz)
            SZ_B:    return off;
            SZ_H:    return {off[2:1], 1'b0};
            SZ_W:    return {off[2], 2'b00};
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [DWORD_BYTES-1:0] size_bytes(input logic [1:0] sz);
        case (sz)
            SZ_B:    return 8'h01;
            SZ_H:    return 8'h03;
            SZ_W:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_load_extend.sv
// ============================================================================
// mem_load_extend : extracts the addressed bytes of a doubleword and
//                   sign- or zero-extends them to 64 bits.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_load_extend
    import mem_access_pkg::*;
(
    input  logic [63:0] rdata_i,
    input  logic [2:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [63:0] result_o
);

    logic [63:0] w_shift;
    logic        w_zext;

    assign w_shift = rdata_i >> {offset_i, 3'b000};
    assign w_zext  = funct3_i[2];

    always_comb begin
        result_o = w_shift;
        case (funct3_i[1:0])
            SZ_B:    result_o = {{56{~w_zext & w_shift[7]}},  w_shift[7:0]};
            SZ_H:    result_o = {{48{~w_zext & w_shift[15]}}, w_shift[15:0]};
            SZ_W:    result_o = {{32{~w_zext & w_shift[31]}}, w_shift[31:0]};
            default: result_o = w_shift;  // ld: offset is always 0 here
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// mem_access_unit : multi-cycle load/store sequencer with byte extraction and
//                   read-modify-write for sub-doubleword stores.
// Build option: MEM_MISALIGN_CHECK_EN turns misaligned accesses into errors.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_access_unit
    import mem_access_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_load,
    input  logic        start_store,
    input  logic [2:0]  funct3,
    input  logic [63:0] addr,
    input  logic [63:0] store_data,
    input  logic [63:0] mem_rdata,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic        mem_we,
    output logic [63:0] load_result,
    output logic        done,
    output logic        busy,
    output logic        err
);

    state_e      state_q, state_d;
    logic [60:0] addr_q;
    logic [2:0]  off_q;
    logic [2:0]  f3_q;
    logic [63:0] wdata_q;
    logic [63:0] load_q;
    logic        err_q;

    logic        w_accept;
    logic        w_bad;
    logic [2:0]  w_off;
    logic [63:0] w_ext;
    logic [7:0]  w_bsel;
    logic [63:0] w_bmask;
    logic [63:0] w_merged;

    assign w_accept = (state_q == S_IDLE) && (start_load || start_store);
    assign w_off    = align_off(funct3[1:0], addr[2:0]);

    always_comb begin
        w_bad = 1'b0;
        if (start_load && start_store)
            w_bad = 1'b1;
        else if (start_load)
            w_bad = (funct3 == F3_LOAD_RSVD);
        else if (start_store)
            w_bad = funct3[2];
`ifdef MEM_MISALIGN_CHECK_EN
        if (w_off != addr[2:0])
            w_bad = 1'b1;
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_load || start_store) begin
                    if (w_bad)
                        state_d = S_DONE;
                    else if (start_load)
                        state_d = S_LD_REQ;
                    else if (funct3[1:0] == SZ_D)
                        state_d = S_ST_WRITE;
                    else
                        state_d = S_ST_RD;
                end
            end
            S_LD_REQ:   state_d = S_LD_CAP;
            S_LD_CAP:   state_d = S_DONE;
            S_ST_RD:    state_d = S_ST_MERGE;
            S_ST_MERGE: state_d = S_ST_WRITE;
            S_ST_WRITE: state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    mem_load_extend u_extend (
        .rdata_i  (mem_rdata),
        .offset_i (off_q),
        .funct3_i (f3_q),
        .result_o (w_ext)
    );

    // Byte-lane mask of the addressed bytes; store data is shifted into place
    assign w_bsel = size_bytes(f3_q[1:0]) << off_q;

    always_comb begin
        w_bmask = '0;
        for (int i = 0; i < DWORD_BYTES; i++)
            w_bmask[8*i +: 8] = {8{w_bsel[i]}};
    end

    assign w_merged = (mem_rdata & ~w_bmask) | ((wdata_q << {off_q, 3'b000}) & w_bmask);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            off_q   <= '0;
            f3_q    <= '0;
            wdata_q <= '0;
            load_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (w_accept) begin
                addr_q <= addr[63:3];
                off_q  <= w_off;
                f3_q   <= funct3;
                err_q  <= w_bad;
                if (start_store)
                    wdata_q <= store_data;
            end
            if (state_q == S_LD_CAP)
                load_q <= w_ext;
            if (state_q == S_ST_MERGE)
                wdata_q <= w_merged;
        end
    end

    assign mem_addr    = {addr_q, 3'b000};
    assign mem_wdata   = wdata_q;
    assign mem_we      = (state_q == S_ST_WRITE);
    assign load_result = load_q;
    assign done        = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE);
    assign err         = err_q && (state_q == S_DONE);

endmodule

`default_nettype wire
